// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//   Decode stage for a 16-bit instruction stream. Immediate-class words
//   (bits [15:14] = 2'b11) consume the following word as a 16-bit immediate.
//   Interrupt requests are injected as a pseudo-instruction between whole
//   instructions, never between an opcode word and its immediate.
//
// State table
//   state | meaning
//   S_OPC | expecting an opcode word (or about to inject an interrupt)
//   S_IMM | expecting the immediate word of a latched immediate-class opcode
//   S_INT | emitting the interrupt pseudo-instruction
//
// Ports
//   i_clk         clock, rising edge
//   i_reset       asynchronous reset, active low
//   i_instr       instruction word from fetch, valid every cycle
//   i_flush       taken-branch flush, discards any in-progress decode
//   i_stall       hazard stall, freezes the stage
//   i_intr        interrupt request (level), latched into a pending flag
//   o_valid       decoded outputs carry an instruction this cycle
//   o_opcode      decoded opcode
//   o_rd/rs1/rs2  register fields
//   o_imm         immediate word, zero unless o_has_imm
//   o_has_imm     o_imm is meaningful
//   o_is_int      interrupt pseudo-instruction marker
//   o_fetch_hold  fetch must hold its PC (combinational)
module instr_decode_stage #(
    parameter logic [4:0] OPC_INT = 5'b10111,
    parameter logic [4:0] OPC_NOP = 5'b00000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_instr,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_intr,
    output logic        o_valid,
    output logic [4:0]  o_opcode,
    output logic [2:0]  o_rd,
    output logic [2:0]  o_rs1,
    output logic [2:0]  o_rs2,
    output logic [15:0] o_imm,
    output logic        o_has_imm,
    output logic        o_is_int,
    output logic        o_fetch_hold
);

    typedef enum logic [1:0] {
        S_OPC = 2'd0,
        S_IMM = 2'd1,
        S_INT = 2'd2
    } state_t;

    state_t     state;
    logic       pending;
    logic [4:0] lat_opcode;
    logic [2:0] lat_rd;
    logic [2:0] lat_rs1;
    logic [2:0] lat_rs2;

    logic [4:0] instr_opcode;
    logic       instr_is_imm;
    logic       intr_take;

    assign instr_opcode = i_instr[15:11];
    assign instr_is_imm = (i_instr[15:14] == 2'b11);
    assign intr_take    = pending || i_intr;

    // Flush redirects fetch, so it overrides every hold request.
    assign o_fetch_hold = i_reset && !i_flush &&
                          (i_stall || (state == S_INT) ||
                           ((state == S_OPC) && intr_take));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= S_OPC;
            pending    <= 1'b0;
            lat_opcode <= '0;
            lat_rd     <= '0;
            lat_rs1    <= '0;
            lat_rs2    <= '0;
            o_valid    <= 1'b0;
            o_opcode   <= '0;
            o_rd       <= '0;
            o_rs1      <= '0;
            o_rs2      <= '0;
            o_imm      <= '0;
            o_has_imm  <= 1'b0;
            o_is_int   <= 1'b0;
        end else if (i_stall && !i_flush) begin
            // Frozen, but a request arriving now must not be lost.
            pending <= pending || i_intr;
        end else begin
            // Every non-stalled cycle starts from an empty output slot.
            o_valid   <= 1'b0;
            o_opcode  <= '0;
            o_rd      <= '0;
            o_rs1     <= '0;
            o_rs2     <= '0;
            o_imm     <= '0;
            o_has_imm <= 1'b0;
            o_is_int  <= 1'b0;
            pending   <= pending || i_intr;

            if (i_flush) begin
                state <= S_OPC;
            end else begin
                case (state)
                    S_OPC: begin
                        if (intr_take) begin
                            // Current word is dropped; fetch holds so it is re-presented.
                            state <= S_INT;
                        end else if (instr_is_imm) begin
                            lat_opcode <= instr_opcode;
                            lat_rd     <= i_instr[10:8];
                            lat_rs1    <= i_instr[7:5];
                            lat_rs2    <= i_instr[4:2];
                            state      <= S_IMM;
                        end else if (instr_opcode != OPC_NOP) begin
                            o_valid  <= 1'b1;
                            o_opcode <= instr_opcode;
                            o_rd     <= i_instr[10:8];
                            o_rs1    <= i_instr[7:5];
                            o_rs2    <= i_instr[4:2];
                        end
                    end
                    S_IMM: begin
                        o_valid   <= 1'b1;
                        o_opcode  <= lat_opcode;
                        o_rd      <= lat_rd;
                        o_rs1     <= lat_rs1;
                        o_rs2     <= lat_rs2;
                        o_imm     <= i_instr;
                        o_has_imm <= 1'b1;
                        state     <= S_OPC;
                    end
                    S_INT: begin
                        o_valid  <= 1'b1;
                        o_opcode <= OPC_INT;
                        o_is_int <= 1'b1;
                        pending  <= 1'b0;
                        state    <= S_OPC;
                    end
                    default: state <= S_OPC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;

    logic        i_clk;
    logic        i_reset;
    logic [15:0] i_instr;
    logic        i_flush;
    logic        i_stall;
    logic        i_intr;
    logic        o_valid;
    logic [4:0]  o_opcode;
    logic [2:0]  o_rd;
    logic [2:0]  o_rs1;
    logic [2:0]  o_rs2;
    logic [15:0] o_imm;
    logic        o_has_imm;
    logic        o_is_int;
    logic        o_fetch_hold;

    int errors = 0;
    int checks = 0;

    instr_decode_stage dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_instr      (i_instr),
        .i_flush      (i_flush),
        .i_stall      (i_stall),
        .i_intr       (i_intr),
        .o_valid      (o_valid),
        .o_opcode     (o_opcode),
        .o_rd         (o_rd),
        .o_rs1        (o_rs1),
        .o_rs2        (o_rs2),
        .o_imm        (o_imm),
        .o_has_imm    (o_has_imm),
        .o_is_int     (o_is_int),
        .o_fetch_hold (o_fetch_hold)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] instr, input logic flush, input logic stall, input logic intr);
        i_instr = instr;
        i_flush = flush;
        i_stall = stall;
        i_intr  = intr;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] opc, input logic [2:0] rd,
                             input logic [2:0] rs1, input logic [2:0] rs2);
        check({tag, " valid"},  32'(o_valid), 32'd1);
        check({tag, " opcode"}, 32'(o_opcode), 32'(opc));
        check({tag, " rd"},     32'(o_rd), 32'(rd));
        check({tag, " rs1"},    32'(o_rs1), 32'(rs1));
        check({tag, " rs2"},    32'(o_rs2), 32'(rs2));
    endtask

    initial begin
        // Reset held with other inputs active: everything must read zero.
        i_reset = 1'b0;
        drive(16'h2A4C, 1'b0, 1'b1, 1'b1);
        #3;
        check("rst valid", 32'(o_valid), 32'd0);
        check("rst hold", 32'(o_fetch_hold), 32'd0);
        step();
        check("rst valid edge", 32'(o_valid), 32'd0);
        check("rst opcode", 32'(o_opcode), 32'd0);
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        i_reset = 1'b1;
        step();
        check("post rst valid", 32'(o_valid), 32'd0);

        // Plain register instruction, then NOP.
        drive(16'h2A4C, 1'b0, 1'b0, 1'b0);
        check("plain hold", 32'(o_fetch_hold), 32'd0);
        step();
        check_reg("reg", 5'b00101, 3'd2, 3'd2, 3'd3);
        check("reg has_imm", 32'(o_has_imm), 32'd0);
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        check("nop valid", 32'(o_valid), 32'd0);

        // Immediate instruction.
        drive(16'hC920, 1'b0, 1'b0, 1'b0);
        step();
        check("imm1 valid", 32'(o_valid), 32'd0);
        drive(16'hBEEF, 1'b0, 1'b0, 1'b0);
        step();
        check_reg("imm2", 5'b11001, 3'd1, 3'd1, 3'd0);
        check("imm2 imm", 32'(o_imm), 32'hBEEF);
        check("imm2 has_imm", 32'(o_has_imm), 32'd1);
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        check("imm3 has_imm", 32'(o_has_imm), 32'd0);
        check("imm3 imm", 32'(o_imm), 32'h0);

        // Flush drops a partial immediate.
        drive(16'hC920, 1'b0, 1'b0, 1'b0);
        step();
        check("fl1 valid", 32'(o_valid), 32'd0);
        drive(16'h1234, 1'b1, 1'b0, 1'b0);
        check("fl hold", 32'(o_fetch_hold), 32'd0);
        step();
        check("fl2 valid", 32'(o_valid), 32'd0);
        check("fl2 has_imm", 32'(o_has_imm), 32'd0);
        drive(16'h2A4C, 1'b0, 1'b0, 1'b0);
        step();
        check_reg("fl3", 5'b00101, 3'd2, 3'd2, 3'd3);

        // Interrupt pulsed during the immediate word.
        drive(16'hC920, 1'b0, 1'b0, 1'b0);
        step();
        drive(16'hBEEF, 1'b0, 1'b0, 1'b1);
        check("ii imm hold", 32'(o_fetch_hold), 32'd0);
        step();
        check("ii imm valid", 32'(o_valid), 32'd1);
        check("ii imm val", 32'(o_imm), 32'hBEEF);
        check("ii imm is_int", 32'(o_is_int), 32'd0);
        drive(16'h2A4C, 1'b0, 1'b0, 1'b0);
        check("ii inj hold", 32'(o_fetch_hold), 32'd1);
        step();
        check("ii inj valid", 32'(o_valid), 32'd0);
        check("ii int hold", 32'(o_fetch_hold), 32'd1);
        step();
        check_reg("ii int", 5'b10111, 3'd0, 3'd0, 3'd0);
        check("ii int is_int", 32'(o_is_int), 32'd1);
        check("ii after hold", 32'(o_fetch_hold), 32'd0);
        step();
        check_reg("ii replay", 5'b00101, 3'd2, 3'd2, 3'd3);
        check("ii replay is_int", 32'(o_is_int), 32'd0);

        // Stall for three cycles with an interrupt pulse inside.
        for (int i = 0; i < 3; i++) begin
            drive(16'h0000, 1'b0, 1'b1, (i == 1));
            #1;
            check("st hold", 32'(o_fetch_hold), 32'd1);
            step();
            check_reg("st frozen", 5'b00101, 3'd2, 3'd2, 3'd3);
        end
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        check("st pend hold", 32'(o_fetch_hold), 32'd1);
        step();
        check("st inj valid", 32'(o_valid), 32'd0);
        step();
        check("st int is_int", 32'(o_is_int), 32'd1);
        check("st int opcode", 32'(o_opcode), 32'(5'b10111));
        step();
        check("st nop valid", 32'(o_valid), 32'd0);
        check("st nop is_int", 32'(o_is_int), 32'd0);

        // Reset mid-immediate, asserted between edges.
        drive(16'h2A4C, 1'b0, 1'b0, 1'b0);
        step();
        check("rm pre valid", 32'(o_valid), 32'd1);
        drive(16'hC920, 1'b0, 1'b0, 1'b0);
        step();
        drive(16'hBEEF, 1'b0, 1'b0, 1'b0);
        #2;
        i_reset = 1'b0;
        #1;
        check("rm valid", 32'(o_valid), 32'd0);
        check("rm hold", 32'(o_fetch_hold), 32'd0);
        step();
        check("rm edge valid", 32'(o_valid), 32'd0);
        #2;
        i_reset = 1'b1;
        #1;
        check("rm rel valid", 32'(o_valid), 32'd0);
        step();
        check_reg("rm beef", 5'b10111, 3'd6, 3'd7, 3'd3);
        check("rm has_imm", 32'(o_has_imm), 32'd0);
        check("rm is_int", 32'(o_is_int), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameter OPC_INT, default 5'b10111, is the opcode emitted for an injected interrupt pseudo-instruction.
REQ-002 Parameter OPC_NOP, default 5'b00000, is the no-operation opcode.
REQ-003 i_clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  is the reset; asynchronous, active-low.
REQ-005 i_instr  input  16  is the instruction word from the fetch stage, valid every cycle.
REQ-006 i_flush  input  1  is the taken-branch flush; it discards any in-progress decode.
REQ-007 i_stall  input  1  is the hazard stall; it freezes the stage.
REQ-008 i_intr  input  1  is the interrupt request, level, sampled each cycle.
REQ-009 o_valid  output  1  means the decoded-instruction outputs carry an instruction this cycle.
REQ-010 o_opcode  output  5  is the decoded opcode, i_instr[15:11].
REQ-011 o_rd, o_rs1, o_rs2  output  3 each  are register fields i_instr[10:8], [7:5], [4:2].
REQ-012 o_imm  output  16  is the immediate word; 16'h0000 when o_has_imm=0.
REQ-013 o_has_imm  output  1  means o_imm is meaningful.
REQ-014 o_is_int  output  1  marks the interrupt pseudo-instruction.
REQ-015 o_fetch_hold  output  1  requests fetch to hold its PC (combinational from state and inputs).

Function
REQ-016 All decoded outputs SHALL be registered; latency from opcode word on i_instr to o_valid=1 is 1 cycle for non-immediate, 2 cycles for immediate instructions.
REQ-017 An instruction is immediate-class when i_instr[15:14]=2'b11; its next word is the immediate.
REQ-018 FSM states: S_OPC (expect opcode word), S_IMM (expect immediate word), S_INT (emit interrupt).
REQ-019 S_OPC, non-immediate, opcode != OPC_NOP: register fields, o_valid=1, o_has_imm=0, stay S_OPC.
REQ-020 S_OPC, opcode = OPC_NOP: o_valid=0, stay S_OPC.
REQ-021 S_OPC, immediate-class: latch opcode/fields internally, o_valid=0, go S_IMM.
REQ-022 S_IMM: register latched fields plus i_instr as o_imm, o_valid=1, o_has_imm=1, go S_OPC.
REQ-023 i_intr asserted in any cycle SHALL set a pending flag; flag clears only when S_INT emits.
REQ-024 In S_OPC with pending flag set (or i_intr=1) and no flush/stall: go S_INT, o_valid=0, o_fetch_hold=1; current i_instr discarded.
REQ-025 S_INT: o_valid=1, o_opcode=OPC_INT, o_is_int=1, register fields 0, clear pending, o_fetch_hold=1, go S_OPC.
REQ-026 An interrupt arriving in S_IMM SHALL NOT split the instruction; it is serviced from the following S_OPC.
REQ-027 i_stall=1: state, pending flag and all outputs hold; o_fetch_hold=1; i_intr still sets pending.
REQ-028 i_flush=1: next cycle o_valid=0, o_has_imm=0, o_is_int=0, state S_OPC; partial immediate dropped; pending flag retained.
REQ-029 Priority: reset > flush > stall > interrupt injection > normal decode.
REQ-030 o_fetch_hold SHALL be 0 in all cases not listed in REQ-024, REQ-025, REQ-027.

Reset
REQ-031 i_reset=0 SHALL immediately force state S_OPC, pending=0, all outputs 0 (o_fetch_hold=0), regardless of clock.
REQ-032 Reset mid-immediate (S_IMM) SHALL discard the latched opcode; first post-reset word is treated as an opcode.
REQ-033 Deasserting i_reset SHALL take effect at the next rising i_clk with no spurious o_valid.

Verification
REQ-034 Stream 16'h2A4C then 16'h0000 -> cycle+1: o_valid=1, o_opcode=5'b00101, o_rd=2, o_rs1=2, o_rs2=3; cycle+2: o_valid=0.
REQ-035 16'hC920, 16'hBEEF -> cycle+1 o_valid=0; cycle+2 o_valid=1, o_opcode=5'b11001, o_imm=16'hBEEF, o_has_imm=1.
REQ-036 16'hC920 then i_flush=1 with 16'h1234 -> no o_valid for either; next word 16'h2A4C decodes normally.
REQ-037 i_intr pulsed during S_IMM -> immediate instruction completes, then one cycle o_is_int=1, o_opcode=5'b10111, o_fetch_hold=1.
REQ-038 i_stall=1 for 3 cycles after valid decode -> outputs frozen, o_fetch_hold=1; i_intr pulse in stall serviced after release.
REQ-039 i_reset=0 asserted mid-cycle in S_IMM -> outputs 0 before next edge; 16'hBEEF after release decodes as opcode 5'b10111 register instruction.
